// File: rtl/arashi_stream_cache.sv
// Multi-thread write staging cache: per-thread FIFOs drained one entry/cycle by an arbiter.
// Write-to-out_valid latency is two edges; the output stage holds while out_valid && !out_ready.
module arashi_stream_cache #(
  parameter int DATA_WIDTH       = 32,
  parameter int THREAD_NUM_WIDTH = 2,
  parameter int DEPTH_WIDTH      = 2,
  parameter int ID_WIDTH         = 1,
  parameter int ARB_MODE         = 0
) (
  input  logic                                           clk,
  input  logic                                           rstn,
  input  logic                                           flush,
  input  logic [(1<<THREAD_NUM_WIDTH)-1:0]               w_valid,
  input  logic [ID_WIDTH*(1<<THREAD_NUM_WIDTH)-1:0]      w_id,
  input  logic [DATA_WIDTH*(1<<THREAD_NUM_WIDTH)-1:0]    data_in,
  output logic [(1<<THREAD_NUM_WIDTH)-1:0]               w_ready,
  input  logic                                           out_ready,
  output logic                                           out_valid,
  output logic [DATA_WIDTH-1:0]                          data_out,
  output logic [ID_WIDTH-1:0]                            id_out,
  output logic [THREAD_NUM_WIDTH-1:0]                    thread_out,
  output logic [(1<<THREAD_NUM_WIDTH)-1:0]               empty
);
  localparam int TN    = 1 << THREAD_NUM_WIDTH;
  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam int TW    = THREAD_NUM_WIDTH;
  localparam int CW    = DEPTH_WIDTH + 1;
  localparam int EW    = DATA_WIDTH + ID_WIDTH;

  logic [EW-1:0]          r_mem  [TN][DEPTH];
  logic [DEPTH_WIDTH-1:0] r_wptr [TN];
  logic [DEPTH_WIDTH-1:0] r_rptr [TN];
  logic [CW-1:0]          r_cnt  [TN];
  // Holds the thread where the next round-robin search begins (last grant + 1).
  logic [TW-1:0]          r_rr;

  logic [TN-1:0] w_push;
  logic [TN-1:0] w_pop;
  logic          w_load;
  logic          w_gnt_vld;
  logic          w_pop_any;
  logic [TW-1:0] w_gnt;
  logic [EW-1:0] w_head;

  always_comb begin
    for (int i = 0; i < TN; i++) begin
      empty[i]   = (r_cnt[i] == '0);
      w_ready[i] = (r_cnt[i] != CW'(DEPTH)) && !flush;
      w_push[i]  = w_valid[i] && w_ready[i];
    end
  end

  always_comb begin
    logic [TW-1:0] idx;
    idx       = '0;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    // Scan from the far end so the candidate closest to the search start wins.
    for (int k = TN - 1; k >= 0; k--) begin
      idx = (ARB_MODE == 1) ? TW'(k) : r_rr + TW'(k);
      if (!empty[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = idx;
      end
    end
  end

  assign w_load    = !out_valid || out_ready;
  assign w_pop_any = w_load && w_gnt_vld && !flush;
  assign w_head    = r_mem[w_gnt][r_rptr[w_gnt]];

  always_comb begin
    for (int i = 0; i < TN; i++) begin
      w_pop[i] = w_pop_any && (w_gnt == TW'(i));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < TN; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < TN; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < TN; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + 1'b1;
        r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < TN; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wptr[i]] <= {w_id[ID_WIDTH*i +: ID_WIDTH], data_in[DATA_WIDTH*i +: DATA_WIDTH]};
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid  <= 1'b0;
      data_out   <= '0;
      id_out     <= '0;
      thread_out <= '0;
      r_rr       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      r_rr      <= '0;
    end else if (w_load) begin
      out_valid <= w_gnt_vld;
      if (w_gnt_vld) begin
        data_out   <= w_head[DATA_WIDTH-1:0];
        id_out     <= w_head[EW-1:DATA_WIDTH];
        thread_out <= w_gnt;
        if (ARB_MODE == 0) r_rr <= w_gnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_arashi_stream_cache.sv
// Bench for arashi_stream_cache: a round-robin and a fixed-priority instance share stimulus,
// each checked against a queue-based reference model and an output scoreboard.
`timescale 1ns/1ps
module tb_arashi_stream_cache;
  localparam int NT = 4;

  typedef struct packed {
    logic [31:0] d;
    logic        id;
    logic [1:0]  t;
  } ent_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic         flush;
  logic [3:0]   wv;
  logic [3:0]   wid;
  logic [127:0] din;
  logic         ordy;

  logic [3:0]  wr    [2];
  logic        ov    [2];
  logic [31:0] dout  [2];
  logic        idout [2];
  logic [1:0]  thout [2];
  logic [3:0]  emp   [2];

  always #5 clk = ~clk;

  arashi_stream_cache #(.ARB_MODE(0)) u_rr (
    .clk(clk), .rstn(rstn), .flush(flush), .w_valid(wv), .w_id(wid), .data_in(din),
    .w_ready(wr[0]), .out_ready(ordy), .out_valid(ov[0]), .data_out(dout[0]),
    .id_out(idout[0]), .thread_out(thout[0]), .empty(emp[0]));

  arashi_stream_cache #(.ARB_MODE(1)) u_fp (
    .clk(clk), .rstn(rstn), .flush(flush), .w_valid(wv), .w_id(wid), .data_in(din),
    .w_ready(wr[1]), .out_ready(ordy), .out_valid(ov[1]), .data_out(dout[1]),
    .id_out(idout[1]), .thread_out(thout[1]), .empty(emp[1]));

  // Reference model: per-thread queues, output-stage flag, next round-robin start.
  ent_t        mq  [2][NT][$];
  ent_t        exq [2][$];
  bit          mv  [2];
  int          rrs [2];
  logic [1:0]  tlog [2][$];
  logic [31:0] dlog [2][$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input bit ok, input string name, input int m,
                     input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, expected %0h at %0t", name, m, act, exp, $time);
    end
  endtask

  function automatic void model_clear(int m);
    for (int t = 0; t < NT; t++) mq[m][t].delete();
    exq[m].delete();
    mv[m]  = 1'b0;
    rrs[m] = 0;
  endfunction

  function automatic void model_step(int m);
    bit   acc [NT];
    int   g;
    int   t;
    ent_t e;
    if (!rstn || flush) begin
      model_clear(m);
      return;
    end
    for (int i = 0; i < NT; i++) acc[i] = wv[i] && (mq[m][i].size() < 4);
    if (!mv[m] || ordy) begin
      g = -1;
      for (int k = 0; k < NT; k++) begin
        t = (m == 1) ? k : (rrs[m] + k) % NT;
        if (g < 0 && mq[m][t].size() > 0) g = t;
      end
      if (g >= 0) begin
        e = mq[m][g].pop_front();
        exq[m].push_back(e);
        mv[m]  = 1'b1;
        rrs[m] = (g + 1) % NT;
      end else begin
        mv[m] = 1'b0;
      end
    end
    for (int i = 0; i < NT; i++) begin
      if (acc[i]) begin
        e.d  = din[32*i +: 32];
        e.id = wid[i];
        e.t  = 2'(i);
        mq[m][i].push_back(e);
      end
    end
  endfunction

  always @(negedge rstn) for (int m = 0; m < 2; m++) model_clear(m);
  always @(posedge clk)  for (int m = 0; m < 2; m++) model_step(m);

  // Monitor: compare state flags every cycle and the output entry against the scoreboard.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      logic [3:0] me;
      logic [3:0] mw;
      for (int t = 0; t < NT; t++) begin
        me[t] = (mq[m][t].size() == 0);
        mw[t] = (mq[m][t].size() < 4) && !flush;
      end
      chk(ov[m] == mv[m], "out_valid", m, ov[m], mv[m]);
      chk(emp[m] == me, "empty", m, emp[m], me);
      chk(wr[m] == mw, "w_ready", m, wr[m], mw);
      if (ov[m]) begin
        chk(exq[m].size() != 0, "scoreboard_underflow", m, 0, 1);
        if (exq[m].size() != 0) begin
          chk(dout[m] == exq[m][0].d, "data_out", m, dout[m], exq[m][0].d);
          chk(idout[m] == exq[m][0].id, "id_out", m, idout[m], exq[m][0].id);
          chk(thout[m] == exq[m][0].t, "thread_out", m, thout[m], exq[m][0].t);
          if (ordy && !flush && rstn) begin
            void'(exq[m].pop_front());
            tlog[m].push_back(thout[m]);
            dlog[m].push_back(dout[m]);
          end
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    for (int m = 0; m < 2; m++) begin
      tlog[m].delete();
      dlog[m].delete();
    end
  endtask

  initial begin
    int exp_rr [8];
    int exp_fp [8];
    exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_fp = '{0, 0, 1, 1, 2, 2, 3, 3};

    rstn  = 1'b0;
    flush = 1'b0;
    wv    = '0;
    wid   = '0;
    din   = '0;
    ordy  = 1'b0;
    #3;
    for (int m = 0; m < 2; m++) begin
      chk(ov[m] == 1'b0, "reset_out_valid", m, ov[m], 0);
      chk(dout[m] == '0, "reset_data_out", m, dout[m], 0);
      chk(idout[m] == 1'b0, "reset_id_out", m, idout[m], 0);
      chk(thout[m] == '0, "reset_thread_out", m, thout[m], 0);
      chk(emp[m] == 4'hF, "reset_empty", m, emp[m], 4'hF);
      chk(wr[m] == 4'hF, "reset_w_ready", m, wr[m], 4'hF);
    end
    cyc(2);
    rstn = 1'b1;
    cyc(2);

    // Single write on thread 2: no bypass, visible one edge after acceptance.
    ordy            = 1'b1;
    wv              = 4'b0100;
    din[64 +: 32]   = 32'hA5A5_0002;
    wid[2]          = 1'b1;
    cyc();
    wv = '0;
    for (int m = 0; m < 2; m++) chk(ov[m] == 1'b0, "no_bypass", m, ov[m], 0);
    cyc();
    for (int m = 0; m < 2; m++) begin
      chk(ov[m] == 1'b1, "t1_out_valid", m, ov[m], 1);
      chk(dout[m] == 32'hA5A5_0002, "t1_data", m, dout[m], 32'hA5A5_0002);
      chk(idout[m] == 1'b1, "t1_id", m, idout[m], 1);
      chk(thout[m] == 2'd2, "t1_thread", m, thout[m], 2);
    end
    cyc();
    for (int m = 0; m < 2; m++) chk(emp[m] == 4'hF, "t1_empty_after", m, emp[m], 4'hF);

    // Fill thread 0 under backpressure: five accepted, the rest refused, drain in order.
    clear_logs();
    ordy = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wv           = 4'b0001;
      din[0 +: 32] = 32'hB000_0000 + i;
      wid[0]       = 1'($urandom);
      cyc();
    end
    wv = '0;
    for (int m = 0; m < 2; m++) chk(wr[m][0] == 1'b0, "full_w_ready", m, wr[m][0], 0);
    ordy = 1'b1;
    cyc(8);
    for (int m = 0; m < 2; m++) begin
      chk(dlog[m].size() == 5, "fill_count", m, dlog[m].size(), 5);
      for (int j = 0; j < 5 && j < dlog[m].size(); j++)
        chk(dlog[m][j] == 32'hB000_0000 + j, "fill_order", m, dlog[m][j], 32'hB000_0000 + j);
    end

    // Two entries per thread, then arbitration order with no bubbles.
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    ordy  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wv  = 4'hF;
      din = {$urandom, $urandom, $urandom, $urandom};
      wid = 4'($urandom);
      cyc();
    end
    wv = '0;
    clear_logs();
    ordy = 1'b1;
    cyc(8);
    chk(tlog[0].size() == 8, "rr_no_bubble", 0, tlog[0].size(), 8);
    chk(tlog[1].size() == 8, "fp_no_bubble", 1, tlog[1].size(), 8);
    for (int j = 0; j < 8 && j < tlog[0].size(); j++)
      chk(tlog[0][j] == 2'(exp_rr[j]), "rr_sequence", 0, tlog[0][j], exp_rr[j]);
    for (int j = 0; j < 8 && j < tlog[1].size(); j++)
      chk(tlog[1][j] == 2'(exp_fp[j]), "fp_sequence", 1, tlog[1][j], exp_fp[j]);
    cyc(2);

    // Backpressure toggling on a held entry.
    clear_logs();
    ordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wv            = 4'b0010;
      din[32 +: 32] = $urandom;
      wid[1]        = 1'($urandom);
      cyc();
    end
    wv = '0;
    for (int r = 0; r < 3; r++) begin
      ordy = 1'b1; cyc();
      ordy = 1'b0; cyc();
      ordy = 1'b0; cyc();
      ordy = 1'b1; cyc();
    end
    ordy = 1'b1;
    cyc(3);
    for (int m = 0; m < 2; m++) chk(dlog[m].size() == 3, "bp_count", m, dlog[m].size(), 3);

    // Flush with entries queued plus a write on thread 1.
    ordy = 1'b0;
    wv   = 4'b1101;
    din  = {$urandom, $urandom, $urandom, $urandom};
    cyc();
    wv = '0;
    cyc();
    flush = 1'b1;
    wv    = 4'b0010;
    cyc();
    flush = 1'b0;
    wv    = '0;
    for (int m = 0; m < 2; m++) begin
      chk(ov[m] == 1'b0, "flush_out_valid", m, ov[m], 0);
      chk(emp[m] == 4'hF, "flush_empty", m, emp[m], 4'hF);
    end
    ordy = 1'b1;
    wv   = 4'b1001;
    din  = {$urandom, $urandom, $urandom, $urandom};
    cyc();
    wv = '0;
    cyc();
    for (int m = 0; m < 2; m++) chk(thout[m] == 2'd0, "post_flush_first", m, thout[m], 0);
    cyc();
    for (int m = 0; m < 2; m++) chk(thout[m] == 2'd3, "post_flush_second", m, thout[m], 3);
    cyc(2);

    // Asynchronous reset mid-drain.
    for (int i = 0; i < 3; i++) begin
      wv  = 4'hF;
      din = {$urandom, $urandom, $urandom, $urandom};
      cyc();
    end
    wv   = '0;
    rstn = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk(ov[m] == 1'b0, "arst_out_valid", m, ov[m], 0);
      chk(emp[m] == 4'hF, "arst_empty", m, emp[m], 4'hF);
      chk(dout[m] == '0, "arst_data_out", m, dout[m], 0);
    end
    cyc();
    rstn = 1'b1;
    cyc();

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      wv    = 4'($urandom);
      din   = {$urandom, $urandom, $urandom, $urandom};
      wid   = 4'($urandom);
      ordy  = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 63) == 0);
      cyc();
    end
    wv    = '0;
    flush = 1'b0;
    ordy  = 1'b1;
    cyc(24);
    for (int m = 0; m < 2; m++) begin
      chk(exq[m].size() == 0, "final_scoreboard_empty", m, exq[m].size(), 0);
      chk(emp[m] == 4'hF, "final_empty", m, emp[m], 4'hF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
